// File: rtl/hello_world_if.sv
// Signal bundle for hello_world: function operands and count clear in,
// combinational/registered function results and the high-cycle count out.
interface hello_world_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             a;
    logic             b;
    logic             c;
    logic             clr_count;
    logic             y;
    logic             y_comb;
    logic             y_rise;
    logic             y_fall;
    logic [CNT_W-1:0] high_count;

    modport master (
        output a, b, c, clr_count,
        input  y, y_comb, y_rise, y_fall, high_count
    );

    modport slave (
        input  a, b, c, clr_count,
        output y, y_comb, y_rise, y_fall, high_count
    );
endinterface

// File: rtl/hello_world.sv
// Three-input truth-table function with a registered copy, edge pulses
// and a saturating count of cycles in which the registered output is high.
module hello_world #(
    parameter logic [7:0]  TRUTH_TABLE = 8'h31,
    parameter int unsigned CNT_W       = 16
) (
    input logic         clk,
    input logic         rst_n,
    hello_world_if.slave bus_io
);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             y_comb;
    logic             y_q;
    logic             y_prev_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        y_comb = TRUTH_TABLE[{bus_io.a, bus_io.b, bus_io.c}];
        cnt_d  = cnt_q;
        // Clear wins over counting; counting uses the pre-edge registered y.
        if (bus_io.clr_count) begin
            cnt_d = '0;
        end else if (y_q && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q      <= 1'b0;
            y_prev_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            y_q      <= y_comb;
            y_prev_q <= y_q;
            rise_q   <= y_q & ~y_prev_q;
            fall_q   <= ~y_q & y_prev_q;
            cnt_q    <= cnt_d;
        end
    end

    assign bus_io.y_comb     = y_comb;
    assign bus_io.y          = y_q;
    assign bus_io.y_rise     = rise_q;
    assign bus_io.y_fall     = fall_q;
    assign bus_io.high_count = cnt_q;
endmodule

// File: tb/tb_hello_world.sv
// Scoreboard bench for hello_world: a wide-counter instance and a 2-bit
// counter instance are driven with identical stimulus.
module tb_hello_world;
    logic clk;
    logic rst_n;

    hello_world_if #(.CNT_W(16)) bus16 ();
    hello_world_if #(.CNT_W(2))  bus2 ();

    hello_world #(.CNT_W(16)) u_dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus16.slave)
    );

    hello_world #(.CNT_W(2)) u_dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        y;
        logic        rise;
        logic        fall;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb_q[$];

    int unsigned checks;
    int unsigned errors;

    // Reference model state (pre-edge values)
    logic        m_y;
    logic        m_prev;
    logic        m_rise;
    logic        m_fall;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;

    function automatic logic f_ref(input logic a, input logic b, input logic c);
        return ~b & (a | ~c);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic a, input logic b, input logic c, input logic clr,
                         input logic rstn);
        exp_t e;
        exp_t got;
        @(negedge clk);
        bus16.a = a; bus16.b = b; bus16.c = c; bus16.clr_count = clr;
        bus2.a  = a; bus2.b  = b; bus2.c  = c; bus2.clr_count  = clr;
        rst_n = rstn;
        #1;
        check_eq("y_comb", {31'd0, bus16.y_comb}, {31'd0, f_ref(a, b, c)});
        check_eq("y_comb_w2", {31'd0, bus2.y_comb}, {31'd0, f_ref(a, b, c)});
        // Mid-cycle input or reset changes must not disturb registered state
        if (!$isunknown(m_y)) begin
            check_eq("y_hold", {31'd0, bus16.y}, {31'd0, m_y});
            check_eq("cnt_hold", {16'd0, bus16.high_count}, {16'd0, m_cnt});
        end
        if (!rstn) begin
            e = '0;
            m_y = 1'b0; m_prev = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            m_cnt = '0; m_cnt2 = '0;
        end else begin
            e.y    = f_ref(a, b, c);
            e.rise = m_y & ~m_prev;
            e.fall = ~m_y & m_prev;
            e.cnt  = clr ? 16'd0 : ((m_y && m_cnt != 16'hffff) ? m_cnt + 16'd1 : m_cnt);
            e.cnt2 = clr ? 2'd0 : ((m_y && m_cnt2 != 2'd3) ? m_cnt2 + 2'd1 : m_cnt2);
            m_prev = m_y;
            m_y    = e.y;
            m_rise = e.rise;
            m_fall = e.fall;
            m_cnt  = e.cnt;
            m_cnt2 = e.cnt2;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got.y    = bus16.y;
        got.rise = bus16.y_rise;
        got.fall = bus16.y_fall;
        got.cnt  = bus16.high_count;
        got.cnt2 = bus2.high_count;
        e = sb_q.pop_front();
        check_eq("y", {31'd0, got.y}, {31'd0, e.y});
        check_eq("y_rise", {31'd0, got.rise}, {31'd0, e.rise});
        check_eq("y_fall", {31'd0, got.fall}, {31'd0, e.fall});
        check_eq("high_count", {16'd0, got.cnt}, {16'd0, e.cnt});
        check_eq("high_count_w2", {30'd0, got.cnt2}, {30'd0, e.cnt2});
        check_eq("rise_fall_excl", {31'd0, got.rise & got.fall}, 32'd0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] abc;
        logic [1:0] bc;
        checks = 0;
        errors = 0;
        m_y = 1'bx; m_prev = 1'bx; m_rise = 1'bx; m_fall = 1'bx;
        m_cnt = 'x; m_cnt2 = 'x;
        rst_n = 1'b0;
        bus16.a = 1'b0; bus16.b = 1'b0; bus16.c = 1'b0; bus16.clr_count = 1'b0;
        bus2.a  = 1'b0; bus2.b  = 1'b0; bus2.c  = 1'b0; bus2.clr_count  = 1'b0;

        do_reset();
        check_eq("rst_y", {31'd0, bus16.y}, 32'd0);
        check_eq("rst_cnt", {16'd0, bus16.high_count}, 32'd0);

        // Exhaustive truth table
        for (int i = 0; i < 8; i++) begin
            abc = i[2:0];
            cycle(abc[2], abc[1], abc[0], 1'b0, 1'b1);
        end

        // a toggles every cycle for each {b,c}
        for (int j = 0; j < 4; j++) begin
            case (j)
                0: bc = 2'b00;
                1: bc = 2'b10;
                2: bc = 2'b11;
                default: bc = 2'b01;
            endcase
            for (int k = 0; k < 6; k++) begin
                cycle(k[0], bc[1], bc[0], 1'b0, 1'b1);
            end
        end

        // Counting from reset, then clear; the 2-bit instance saturates
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("count_10", {16'd0, bus16.high_count}, 32'd9);
        check_eq("sat_w2", {30'd0, bus2.high_count}, 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("count_clr", {16'd0, bus16.high_count}, 32'd0);

        // Clear while y is high
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("y_before_clr", {31'd0, bus16.y}, 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("clr_beats_count", {16'd0, bus16.high_count}, 32'd0);

        // Reset mid-run with y high and count 5
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("pre_rst_cnt", {16'd0, bus16.high_count}, 32'd5);
        check_eq("pre_rst_y", {31'd0, bus16.y}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("mid_rst_cnt", {16'd0, bus16.high_count}, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        // First edge out of reset loads y_comb, rise follows a cycle later
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
